// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file: clear FSM states,
// default geometry and write-port priority resolution.
package reg_file_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 3;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } clr_state_e;

  // hit: some enabled port targets this address; port1: the winning data is port 1's.
  typedef struct packed {
    logic hit;
    logic port1;
  } wr_sel_t;

  // Port 0 has fixed priority; port 1 only wins when port 0 does not hit.
  function automatic wr_sel_t wr_resolve(input logic en0, input logic match0,
                                         input logic en1, input logic match1);
    wr_sel_t sel;
    sel.hit   = (en0 & match0) | (en1 & match1);
    sel.port1 = ~(en0 & match0);
    return sel;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: array lookup, optional write bypass and
// optional hard-wired zero register.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
  input  logic              fwd_en_i,
  input  logic              wr_en_0_i,
  input  logic [ADDR_W-1:0] wr_addr_0_i,
  input  logic [DATA_W-1:0] wr_data_0_i,
  input  logic              wr_en_1_i,
  input  logic [ADDR_W-1:0] wr_addr_1_i,
  input  logic [DATA_W-1:0] wr_data_1_i,
  output logic [DATA_W-1:0] rd_data_o
);

  wr_sel_t sel;

  always_comb begin
    sel = wr_resolve(wr_en_0_i, wr_addr_0_i == rd_addr_i,
                     wr_en_1_i, wr_addr_1_i == rd_addr_i);
    rd_data_o = mem_i[rd_addr_i];
    // Forward only writes that will actually commit on the coming edge.
    if (BYPASS && fwd_en_i && sel.hit) begin
      rd_data_o = sel.port1 ? wr_data_1_i : wr_data_0_i;
    end
    if (ZERO_R0 && (rd_addr_i == '0)) begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/reg_file_multi.sv
// Two-write/two-read general-purpose register bank with port-0 write priority,
// optional bypass and zero register, and a one-entry-per-cycle bulk-clear sweep.
module reg_file_multi
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_0,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [DATA_W-1:0] wr_data_0,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic [ADDR_W-1:0] rd_addr_A,
  input  logic [ADDR_W-1:0] rd_addr_B,
  output logic [DATA_W-1:0] rd_data_A,
  output logic [DATA_W-1:0] rd_data_B,
  input  logic              clr_start,
  output logic              busy,
  output logic              wr_drop
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              wr_accept;

  // A clear request in the same cycle pre-empts any writes.
  assign wr_accept = (state_q == StIdle) && !clr_start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = (wr_en_0 || wr_en_1) && !wr_accept;
    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_sel_t sel;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sel = wr_resolve(wr_en_0, wr_addr_0 == ADDR_W'(i), wr_en_1, wr_addr_1 == ADDR_W'(i));
      mem_d[i] = mem_q[i];
      if (state_q == StClear) begin
        if (cnt_q == ADDR_W'(i)) begin
          mem_d[i] = '0;
        end
      end else if (wr_accept && sel.hit) begin
        mem_d[i] = sel.port1 ? wr_data_1 : wr_data_0;
      end
    end
    if (ZERO_R0) begin
      mem_d[0] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      mem_q   <= mem_d;
    end
  end

  assign busy    = (state_q == StClear);
  assign wr_drop = drop_q;

  reg_file_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS),
    .ZERO_R0 (ZERO_R0)
  ) u_rd_a (
    .rd_addr_i   (rd_addr_A),
    .mem_i       (mem_q),
    .fwd_en_i    (wr_accept),
    .wr_en_0_i   (wr_en_0),
    .wr_addr_0_i (wr_addr_0),
    .wr_data_0_i (wr_data_0),
    .wr_en_1_i   (wr_en_1),
    .wr_addr_1_i (wr_addr_1),
    .wr_data_1_i (wr_data_1),
    .rd_data_o   (rd_data_A)
  );

  reg_file_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS),
    .ZERO_R0 (ZERO_R0)
  ) u_rd_b (
    .rd_addr_i   (rd_addr_B),
    .mem_i       (mem_q),
    .fwd_en_i    (wr_accept),
    .wr_en_0_i   (wr_en_0),
    .wr_addr_0_i (wr_addr_0),
    .wr_data_0_i (wr_data_0),
    .wr_en_1_i   (wr_en_1),
    .wr_addr_1_i (wr_addr_1),
    .wr_data_1_i (wr_data_1),
    .rd_data_o   (rd_data_B)
  );

endmodule

// File: tb/tb_reg_file_multi.sv
// Drives three register-file variants (default, no bypass, zero r0) with shared
// stimulus and checks them every cycle against an array-based model.
module tb_reg_file_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic we0, we1, clr;
  logic [2:0] wa0, wa1, ra, rb;
  logic [15:0] wd0, wd1;
  logic [2:0][15:0] rd_a, rd_b;
  logic [2:0] busy_v, drop_v;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt;
  logic [15:0] fill [6] = '{16'habcd, 16'h1234, 16'h3456, 16'h5678, 16'h9122, 16'h6768};

  always #5 clk = ~clk;

  reg_file_multi u_dut (
    .clk(clk), .rst(rst),
    .wr_en_0(we0), .wr_addr_0(wa0), .wr_data_0(wd0),
    .wr_en_1(we1), .wr_addr_1(wa1), .wr_data_1(wd1),
    .rd_addr_A(ra), .rd_addr_B(rb), .rd_data_A(rd_a[0]), .rd_data_B(rd_b[0]),
    .clr_start(clr), .busy(busy_v[0]), .wr_drop(drop_v[0])
  );

  reg_file_multi #(.BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst),
    .wr_en_0(we0), .wr_addr_0(wa0), .wr_data_0(wd0),
    .wr_en_1(we1), .wr_addr_1(wa1), .wr_data_1(wd1),
    .rd_addr_A(ra), .rd_addr_B(rb), .rd_data_A(rd_a[1]), .rd_data_B(rd_b[1]),
    .clr_start(clr), .busy(busy_v[1]), .wr_drop(drop_v[1])
  );

  reg_file_multi #(.ZERO_R0(1'b1)) u_dut_z (
    .clk(clk), .rst(rst),
    .wr_en_0(we0), .wr_addr_0(wa0), .wr_data_0(wd0),
    .wr_en_1(we1), .wr_addr_1(wa1), .wr_data_1(wd1),
    .rd_addr_A(ra), .rd_addr_B(rb), .rd_data_A(rd_a[2]), .rd_data_B(rd_b[2]),
    .clr_start(clr), .busy(busy_v[2]), .wr_drop(drop_v[2])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Model: variant 0 = default, 1 = no bypass, 2 = zero register 0.
  bit [15:0] m_mem [3][8];
  bit        m_busy;
  int        m_cnt;
  bit        m_drop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++)
        for (int a = 0; a < 8; a++) m_mem[k][a] <= '0;
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_drop <= 1'b0;
    end else if (m_busy) begin
      for (int k = 0; k < 3; k++) m_mem[k][m_cnt] <= '0;
      m_drop <= we0 || we1;
      if (m_cnt == 7) begin
        m_busy <= 1'b0;
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (clr) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_drop <= we0 || we1;
    end else begin
      m_drop <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        // Port 0 assigned last so it wins on an address collision.
        if (we1 && !(k == 2 && wa1 == 3'd0)) m_mem[k][wa1] <= wd1;
        if (we0 && !(k == 2 && wa0 == 3'd0)) m_mem[k][wa0] <= wd0;
      end
    end
  end

  function automatic logic [15:0] exp_rd(input int k, input logic [2:0] a);
    if (k == 2 && a == 3'd0) return 16'h0;
    if (k != 1 && !m_busy && !clr) begin
      if (we0 && wa0 == a) return wd0;
      if (we1 && wa1 == a) return wd1;
    end
    return m_mem[k][a];
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("cmp_rdA_v%0d", k), rd_a[k], exp_rd(k, ra));
      check($sformatf("cmp_rdB_v%0d", k), rd_b[k], exp_rd(k, rb));
      check($sformatf("cmp_busy_v%0d", k), busy_v[k], m_busy);
      check($sformatf("cmp_drop_v%0d", k), drop_v[k], m_drop);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    we0 = 0; we1 = 0; clr = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; ra = 0; rb = 0;
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy_v[0], 0);
    check("reset_drop", drop_v[0], 0);
    check("reset_rdA", rd_a[0], 0);
    tick();
    rst = 1'b1;

    // Sequential fill through port 0.
    for (int i = 0; i < 6; i++) begin
      we0 = 1; wa0 = 3'(i); wd0 = fill[i];
      tick();
    end
    we0 = 0; ra = 3'd1; rb = 3'd2;
    @(negedge clk);
    check("fill_rdA", rd_a[1], 16'h1234);
    check("fill_rdB", rd_b[1], 16'h3456);

    // Same-address collision, then two distinct addresses.
    tick();
    we0 = 1; wa0 = 3'd3; wd0 = 16'hAAAA; we1 = 1; wa1 = 3'd3; wd1 = 16'h5555;
    tick();
    we0 = 1; wa0 = 3'd4; wd0 = 16'h1111; wa1 = 3'd6; wd1 = 16'h2222; ra = 3'd3;
    @(negedge clk);
    check("collide_p0_wins", rd_a[1], 16'hAAAA);
    check("collide_no_drop", drop_v[0], 0);
    tick();
    we0 = 0; we1 = 0; ra = 3'd4; rb = 3'd6;
    @(negedge clk);
    check("dual_wr_4", rd_a[1], 16'h1111);
    check("dual_wr_6", rd_b[1], 16'h2222);

    // Bypass vs no bypass on register 7.
    tick();
    ra = 3'd7; we1 = 1; wa1 = 3'd7; wd1 = 16'hBEEF;
    @(negedge clk);
    check("bypass_same_cycle", rd_a[0], 16'hBEEF);
    check("nobypass_old", rd_a[1], 16'h0000);
    tick();
    we1 = 0;
    @(negedge clk);
    check("nobypass_next", rd_a[1], 16'hBEEF);

    // Fill everything, then sweep with a write attempt mid-sweep.
    tick();
    for (int i = 0; i < 4; i++) begin
      we0 = 1; wa0 = 3'(2 * i); wd0 = 16'($urandom_range(1, 16'hFFFF));
      we1 = 1; wa1 = 3'(2 * i + 1); wd1 = 16'($urandom_range(1, 16'hFFFF));
      tick();
    end
    we0 = 0; we1 = 0; clr = 1;
    tick();
    clr = 0; rb = 3'd7;
    busy_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      ra = 3'(j);
      @(negedge clk);
      if (busy_v[0]) busy_cnt++;
      if (j == 4) check("drop_after_clear_write", drop_v[0], 1);
      tick();
      we0 = (j == 2); wa0 = 3'd2; wd0 = 16'h7777;
    end
    we0 = 0;
    check("busy_cycles", busy_cnt, 8);
    for (int i = 0; i < 4; i++) begin
      ra = 3'(2 * i); rb = 3'(2 * i + 1);
      @(negedge clk);
      check("post_clear_A", rd_a[0], 0);
      check("post_clear_B", rd_b[0], 0);
      tick();
    end

    // Zero register variant.
    we0 = 1; wa0 = 3'd0; wd0 = 16'hFFFF; we1 = 1; wa1 = 3'd1; wd1 = 16'h1357;
    tick();
    we0 = 0; we1 = 0; ra = 3'd0; rb = 3'd1;
    @(negedge clk);
    check("zero_r0_read", rd_a[2], 0);
    check("zero_r1_read", rd_b[2], 16'h1357);
    check("zero_no_drop", drop_v[2], 0);
    check("nonzero_r0_read", rd_a[0], 16'hFFFF);

    // Reset in the middle of a sweep.
    tick();
    clr = 1;
    tick();
    clr = 0;
    repeat (3) tick();
    check("busy_before_reset", busy_v[0], 1);
    #1 rst = 1'b0;
    #1 check("busy_async_reset", busy_v[0], 0);
    for (int i = 0; i < 4; i++) begin
      ra = 3'(2 * i); rb = 3'(2 * i + 1);
      @(negedge clk);
      check("reset_zero_A", rd_a[0], 0);
      check("reset_zero_B", rd_b[0], 0);
    end
    tick();
    rst = 1'b1;
    we0 = 1; wa0 = 3'd5; wd0 = 16'h0F0F; ra = 3'd5;
    tick();
    we0 = 0;
    @(negedge clk);
    check("write_after_reset", rd_a[1], 16'h0F0F);

    // Randomised traffic with occasional clears.
    tick();
    repeat (2000) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = 3'($urandom); wd0 = 16'($urandom);
      we1 = 1'($urandom_range(0, 1)); wa1 = 3'($urandom); wd1 = 16'($urandom);
      ra = 3'($urandom); rb = 3'($urandom);
      clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    we0 = 0; we1 = 0; clr = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_multi.md
Name: reg_file_multi

Overview:
- Parametrised successor to the team's 8x16 two-read/one-write register file, used as the datapath general-purpose register bank.
- Generalised in data width and depth.
- Adds a second write port with fixed priority, optional same-cycle write-to-read bypass, optional hard-wired zero register, and a sequential bulk-clear engine with busy/drop signalling.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads show array contents only.
- ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- wr_en_0  in  1  write enable, port 0 (high priority).
- wr_addr_0  in  ADDR_W  write address, port 0.
- wr_data_0  in  DATA_W  write data, port 0.
- wr_en_1  in  1  write enable, port 1.
- wr_addr_1  in  ADDR_W  write address, port 1.
- wr_data_1  in  DATA_W  write data, port 1.
- rd_addr_A  in  ADDR_W  read address A.
- rd_addr_B  in  ADDR_W  read address B.
- rd_data_A  out  DATA_W  read data A (combinational).
- rd_data_B  out  DATA_W  read data B (combinational).
- clr_start  in  1  single-cycle pulse requesting bulk clear.
- busy  out  1  high while the clear sweep runs.
- wr_drop  out  1  registered one-cycle pulse: a write was discarded.

Behaviour:
- Reset (rst=0, asynchronous):
  - all DEPTH registers cleared to 0.
  - FSM goes to IDLE, sweep counter cleared to 0.
  - busy=0, wr_drop=0.
- Writes:
  - committed on the rising clk edge when wr_en_x=1 and FSM is IDLE.
  - both ports may write different addresses in the same cycle.
  - same address on both ports: port 0 data wins, and port 1 is not counted as a drop.
- Reads:
  - combinational from the array.
  - BYPASS=1: if the read address matches an enabled write in the same cycle, forward that write data, port 0 taking precedence over port 1.
  - BYPASS=1 does not forward while busy=1.
- ZERO_R0=1: reads of address 0 return 0, and writes to address 0 are silently ignored (not drops).
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clk edge with clr_start=1. The counter starts at 0 and busy rises on that edge.
  - CLEAR: each cycle, register[counter] is set to 0 and the counter increments.
  - The sweep takes exactly DEPTH cycles. After the edge that clears register DEPTH-1, the FSM returns to IDLE and busy falls.
  - clr_start while busy is ignored.
  - clr_start together with writes in IDLE: the clear takes effect and those writes are dropped (wr_drop=1 next cycle).
  - Reads during CLEAR return the current array contents: cleared entries read 0, uncleared entries read their old value.
- wr_drop: asserted for one cycle after any edge where wr_en_0 or wr_en_1 was high and the write was discarded because of CLEAR or a simultaneous clr_start.
- Counter wraps naturally at DEPTH. No terminal-count overflow exists because the exit is tested at DEPTH-1.
- Reset mid-sweep aborts the sweep; the array is zero regardless.
- Latency:
  - write to visible on read: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
  - clr_start to busy: 1 edge.

Decomposition:
- Shared package reg_file_pkg holds:
  - clear FSM state enum (IDLE, CLEAR).
  - default DATA_W/ADDR_W constants.
  - function for write-port priority resolution.
- One natural sub-module, reg_file_read_port, instantiated twice.
  - Contains: address decode, bypass mux and zero-register mask for one read port.
  - Parameters: DATA_W, ADDR_W, BYPASS, ZERO_R0.

Test Plan:
- Reset then sequential fill: write port 0 addr 0..5 with 16'habcd,16'h1234,16'h3456,16'h5678,16'h9122,16'h6768; then rd_addr_A=1, rd_addr_B=2 -> rd_data_A=16'h1234, rd_data_B=16'h3456.
- Dual write, same cycle: port 0 addr 3=16'hAAAA and port 1 addr 3=16'h5555 -> reg 3 reads 16'hAAAA, wr_drop stays 0. Port 0 addr 4=16'h1111 and port 1 addr 6=16'h2222 -> both stored.
- Bypass, BYPASS=1: rd_addr_A=7, and port 1 writes addr 7=16'hBEEF -> rd_data_A=16'hBEEF in the same cycle. Repeat with BYPASS=0 -> old value this cycle, 16'hBEEF next cycle.
- Clear sweep: array fully written, then pulse clr_start -> busy high for exactly 8 cycles. Reg k reads 0 from cycle k+1. A port 0 write to addr 2 at cycle 3 is discarded and wr_drop pulses one cycle later. All regs read 0 at the end.
- ZERO_R0=1: write 16'hFFFF to addr 0 -> reads 0, wr_drop=0. Write addr 1 is unaffected.
- Reset asserted at cycle 4 of the sweep -> busy falls immediately (asynchronously). All regs read 0. After release, a write to addr 5=16'h0F0F is accepted the next edge.
